branch_predictor_2lvl: RTL

Parametrised two-level branch predictor for the fetch stage: a per-address branch history table (BHT) indexes a pattern history table (PHT) of saturating counters. It generalises the local predictor with configurable counter width, a selectable local or global-XOR (gshare-style) PHT index mode, a registered prediction valid/strength output and built-in accuracy counters. It sits beside the PC generator; the execute stage feeds back resolved outcomes on the renew port.

---
 rtl/branch_predictor_2lvl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/branch_predictor_2lvl.sv
// ---------------------------------------------------------------------------
// branch_predictor_2lvl
//
// Two-level branch predictor for the fetch stage. A per-address branch
// history table (BHT) supplies the index into a pattern history table (PHT)
// of saturating counters. The PHT index is either the local history alone
// (INDEX_MODE=0) or the local history XOR the global history register
// (INDEX_MODE=1, gshare-style). Accuracy counters track resolved branches and
// mispredictions.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   predict_valid       prediction request for predict_addr this cycle
//   predict_addr        low PC bits of the branch to predict
//   predict_out_valid   predict_result / predict_strong valid (1-cycle latency)
//   predict_result      1 = predicted taken
//   predict_strong      counter sits at a saturated end (0 or all-ones)
//   renew_valid         resolved branch update this cycle
//   renew_addr          low PC bits of the resolved branch
//   renew_result        actual outcome, 1 = taken
//   last_predict        prediction that was issued for the resolved branch
//   stat_total          number of renew events (saturating)
//   stat_miss           renew events with last_predict != renew_result
//   stat_clear          synchronous clear of both stat counters
//
// Valid semantics: predict_valid and renew_valid are single-cycle qualifiers
// with no backpressure; each is consumed at the rising edge where it is
// sampled high. predict_out_valid is high for exactly one cycle per accepted
// request, one edge later.
// ---------------------------------------------------------------------------
module branch_predictor_2lvl #(
  parameter int LOW_ADDR_WIDTH       = 8,
  parameter int BRANCH_HISTORY_WIDTH = 4,
  parameter int COUNTER_WIDTH        = 2,
  parameter int INDEX_MODE           = 0,
  parameter int STAT_WIDTH           = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      predict_valid,
  input  logic [LOW_ADDR_WIDTH-1:0] predict_addr,
  output logic                      predict_out_valid,
  output logic                      predict_result,
  output logic                      predict_strong,
  input  logic                      renew_valid,
  input  logic [LOW_ADDR_WIDTH-1:0] renew_addr,
  input  logic                      renew_result,
  input  logic                      last_predict,
  output logic [STAT_WIDTH-1:0]     stat_total,
  output logic [STAT_WIDTH-1:0]     stat_miss,
  input  logic                      stat_clear
);

  localparam int BHT_DEPTH = 1 << LOW_ADDR_WIDTH;
  localparam int PHT_DEPTH = 1 << BRANCH_HISTORY_WIDTH;
  localparam int H         = BRANCH_HISTORY_WIDTH;

  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = {COUNTER_WIDTH{1'b1}};
  // Weakly not-taken: 2^(C-1)-1, which is all-ones shifted right by one.
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic                     USE_GHR  = (INDEX_MODE != 0);

  logic [H-1:0]             bht [BHT_DEPTH];
  logic [COUNTER_WIDTH-1:0] pht [PHT_DEPTH];
  logic [H-1:0]             ghr;

  logic [H-1:0]             ghr_mix;
  logic [H-1:0]             pred_idx;
  logic [H-1:0]             renew_idx;
  logic [H-1:0]             renew_hist;
  logic [COUNTER_WIDTH-1:0] pred_ctr;
  logic [COUNTER_WIDTH-1:0] renew_ctr;
  logic [COUNTER_WIDTH-1:0] renew_ctr_next;

  // All reads come from the current (pre-update) state, so a same-cycle
  // predict and renew naturally see read-old behaviour with no bypass.
  assign ghr_mix    = USE_GHR ? ghr : '0;
  assign pred_idx   = bht[predict_addr] ^ ghr_mix;
  assign renew_hist = bht[renew_addr];
  assign renew_idx  = renew_hist ^ ghr_mix;
  assign pred_ctr   = pht[pred_idx];
  assign renew_ctr  = pht[renew_idx];

  always_comb begin
    renew_ctr_next = renew_ctr;
    if (renew_result) begin
      if (renew_ctr != CTR_MAX) renew_ctr_next = renew_ctr + 1'b1;
    end else begin
      if (renew_ctr != '0) renew_ctr_next = renew_ctr - 1'b1;
    end
  end

  // History and pattern tables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= '0;
      for (int j = 0; j < PHT_DEPTH; j++) pht[j] <= CTR_INIT;
      ghr <= '0;
    end else if (renew_valid) begin
      pht[renew_idx]  <= renew_ctr_next;
      bht[renew_addr] <= {renew_hist[H-2:0], renew_result};
      ghr             <= {ghr[H-2:0], renew_result};
    end
  end

  // Registered prediction; result/strength hold when no request is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_out_valid <= 1'b0;
      predict_result    <= 1'b0;
      predict_strong    <= 1'b0;
    end else begin
      predict_out_valid <= predict_valid;
      if (predict_valid) begin
        predict_result <= pred_ctr[COUNTER_WIDTH-1];
        predict_strong <= (pred_ctr == '0) || (pred_ctr == CTR_MAX);
      end
    end
  end

  // Accuracy counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= '0;
      stat_miss  <= '0;
    end else if (stat_clear) begin
      stat_total <= '0;
      stat_miss  <= '0;
    end else if (renew_valid) begin
      if (stat_total != {STAT_WIDTH{1'b1}}) stat_total <= stat_total + 1'b1;
      if ((last_predict != renew_result) && (stat_miss != {STAT_WIDTH{1'b1}}))
        stat_miss <= stat_miss + 1'b1;
    end
  end

endmodule
